// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared interface bus. It grants one producer,
// muxes its data onto o_y and frames the consumer latch enable with setup and hold cycles.
module shared_bus_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic [1:0]       i_req,
  input  logic [1:0]       i_last,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  output logic [1:0]       o_gnt,
  output logic [WIDTH-1:0] o_y,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] MAX_BEATS = 4'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [3:0]       beat_q, beat_d;

  logic             winner;
  logic [WIDTH-1:0] winner_data;
  logic [WIDTH-1:0] owner_data;
  logic             xfer_done;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      y_q          <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      owner_q      <= 1'b1;
      last_owner_q <= 1'b1;
      beat_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      y_q          <= y_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
    end
  end

  // On contention the requester that did not own the bus last time wins.
  always_comb begin
    if (i_req == 2'b11) begin
      winner = ~last_owner_q;
    end else begin
      winner = i_req[1];
    end
    winner_data = winner ? i_data1 : i_data0;
    owner_data  = owner_q ? i_data1 : i_data0;
    xfer_done   = i_last[owner_q] || !i_req[owner_q] || (beat_q == MAX_BEATS);
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    y_d          = y_q;
    en_d         = en_q;
    busy_d       = busy_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;

    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        en_d  = 1'b0;
        if (|i_req) begin
          state_d = SETUP;
          gnt_d   = winner ? 2'b10 : 2'b01;
          owner_d = winner;
          busy_d  = 1'b1;
          y_d     = winner_data;
        end
      end
      SETUP: begin
        state_d = XFER;
        y_d     = owner_data;
        en_d    = 1'b1;
        beat_d  = 4'd1;
      end
      XFER: begin
        // The exit edge leaves o_y untouched so the final beat is held after the latch closes.
        if (xfer_done) begin
          state_d      = RELEASE;
          en_d         = 1'b0;
          gnt_d        = 2'b00;
          last_owner_d = owner_q;
          beat_d       = 4'd0;
        end else begin
          y_d    = owner_data;
          beat_d = beat_q + 4'd1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        en_d    = 1'b0;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_gnt   = gnt_q;
  assign o_y     = y_q;
  assign o_en    = en_q;
  assign o_busy  = busy_q;
  assign o_owner = owner_q;

endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the 8-bit shared interface bus `y`.
- The bus is driven by producer submodules and captured by a level-sensitive latch in the consumer submodule, gated by `en`.
- The block grants one producer at a time (round-robin), muxes its data onto `o_y`, and generates the consumer latch enable with guaranteed setup and hold cycles.
- It sits in the top level between the producers and the consumer, replacing the free-running `en` input.

Parameters:
- WIDTH, 8, data width of the shared bus.
- MAX_HOLD, 4, maximum number of XFER beats per grant before forced release (range 1..15).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_arst  input  1  reset, synchronous, active-high.
- i_req  input  2  per-requester bus request, level, bit n = requester n.
- i_last  input  2  per-requester last-beat flag, sampled only while that requester is granted and in XFER.
- i_data0  input  WIDTH  requester 0 data.
- i_data1  input  WIDTH  requester 1 data.
- o_gnt  output  2  one-hot grant, registered.
- o_y  output  WIDTH  shared bus to consumer latch D, registered.
- o_en  output  1  consumer latch enable (latch transparent when high), registered.
- o_busy  output  1  high in any state other than IDLE.
- o_owner  output  1  index of current or most recent owner.

Behaviour:
- One clock, i_clk.
- Reset is synchronous, active-high: i_arst sampled high at a rising edge forces the following on that edge, regardless of state:
  - state = IDLE
  - o_gnt = 2'b00, o_en = 0, o_y = 0, o_busy = 0
  - beat counter = 0
  - last_owner = 1, so requester 0 wins the first contended arbitration
  - o_owner = 1
- All outputs come from flops; there are no combinational input-to-output paths.
- FSM states: IDLE, SETUP, XFER, RELEASE.
- IDLE:
  - o_gnt = 0, o_en = 0; o_y holds its last value.
  - If any i_req bit is set, select the winner:
    - single request: that requester;
    - both requests: the requester != last_owner.
  - Next edge: state = SETUP, o_gnt = onehot(winner), o_owner = winner, o_busy = 1.
- SETUP (exactly 1 cycle):
  - o_y loads the winner's data; o_en stays 0 so data is stable before the latch opens.
  - Next edge: state = XFER, o_en = 1, beat counter = 1.
- XFER:
  - o_en = 1.
  - o_y reloads the granted requester's data every cycle (1-cycle latency from i_dataN to o_y).
  - Beat counter increments each cycle.
  - Exit to RELEASE at the next edge if any of these hold:
    - i_last[owner] = 1;
    - i_req[owner] = 0;
    - beat counter == MAX_HOLD.
  - The beat in which i_last is sampled is the final beat captured.
- RELEASE (exactly 1 cycle):
  - o_en = 0 and o_gnt = 0 at entry.
  - o_y holds the final beat unchanged, giving 1 cycle of hold after the latch closes.
  - last_owner = owner.
  - Next edge: state = IDLE, o_busy = 0.
- A grant is never issued in RELEASE. Minimum turnaround between grants is 2 cycles (RELEASE then IDLE).
- A request arriving while busy waits. No request is lost if it is held. Requests are level, not pulse.
- i_last is ignored outside XFER and for the non-owner.
- A non-owner deasserting i_req has no effect.
- MAX_HOLD = 1 gives a single-beat transfer: SETUP, XFER for 1 cycle, RELEASE.
- Counter width is 4 bits. The counter never wraps because exit occurs at MAX_HOLD.
- o_gnt is one-hot or zero at all times; o_en = 1 only in XFER.
- o_en = 1 implies exactly one o_gnt bit is set.

Test Plan:
- Reset then i_req = 01, i_data0 = 8'hA5, i_last[0] raised on the 3rd XFER beat -> o_gnt = 01 one cycle after req; o_en high for exactly 3 cycles; o_y = A5 one cycle before o_en rises and for one cycle after it falls; then IDLE.
- i_req = 11 held from reset, i_last = 11 -> grants alternate 01, 10, 01; each burst is 1 beat; gap between grants is 2 cycles; first winner is requester 0.
- i_req = 10 held, i_last = 0, MAX_HOLD = 4 -> o_en high for exactly 4 cycles, forced RELEASE, requester 1 re-granted after 2 idle cycles; o_y tracks i_data1 counting 10, 11, 12, 13 with 1-cycle lag.
- Owner drops i_req on the 2nd XFER beat -> RELEASE next edge; o_en high for 2 cycles; o_y frozen at the last sampled data during RELEASE.
- i_arst asserted for 1 cycle mid-XFER (o_y = 3C) -> next edge: o_en = 0, o_gnt = 0, o_y = 0, o_busy = 0; then with i_req = 11, requester 0 wins.
- Invariant checks across all tests: o_en = 1 implies onehot(o_gnt); o_gnt is never 11; o_y stable whenever o_en falls.
